mfe_ingress: RTL and testbench
==============================

// Module: mfe_ingress
// PURPOSE
//  Upstream feeder stage for mfe. Packs a byte stream into fixed-size dead-drop request frames:
//  a big-endian drop-ID header followed by a fixed payload. Validates frame length and drops
//  malformed frames. Presents each complete frame to mfe over a valid/ready handshake.
// PARAMETERS
//  ID_BYTES   4   header bytes forming out_drop_id (MSB byte first)
//  MSG_BYTES  16  payload bytes per frame (first byte lands in out_payload[8*MSG_BYTES-1 -: 8])
//  CNT_W      16  width of saturating statistics counters
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  in_valid     in   1              byte on in_data is valid
//  in_data      in   8              stream byte
//  in_last      in   1              marks final byte of a message (qualified by in_valid)
//  in_ready     out  1              byte accepted when in_valid && in_ready
//  out_valid    out  1              frame available to mfe
//  out_ready    in   1              mfe accepts frame when out_valid && out_ready
//  out_drop_id  out  8*ID_BYTES     drop ID of held frame
//  out_payload  out  8*MSG_BYTES    payload of held frame
//  err_pulse    out  1              one-cycle pulse on malformed frame
//  err_code     out  2              01 short, 10 long; valid with err_pulse, else 00
//  frame_cnt    out  CNT_W          good frames delivered to mfe, saturating
//  err_cnt      out  CNT_W          malformed frames, saturating
// BEHAVIOUR
//  - Reset: state=S_ID, byte counter=0, in_ready=0 during rst cycle then 1.
//    out_valid/err_pulse/err_code/frame_cnt/err_cnt=0. out_drop_id/out_payload=0.
//    Reset mid-frame or mid-hold discards the partial or held frame; no error is counted.
//  - FRAME_LEN = ID_BYTES+MSG_BYTES. Byte counter counts accepted bytes 0..FRAME_LEN-1.
//  - FSM, 4 states:
//    S_ID: shift bytes into the ID register; after byte ID_BYTES-1 go to S_PAY.
//    S_PAY: shift bytes into the payload register.
//    S_HOLD: out_valid=1, in_ready=0. On out_ready go to S_ID, count=0, frame_cnt++.
//    S_DISCARD: in_ready=1. Swallow bytes until one with in_last=1, then go to S_ID.
//  - in_ready=1 in S_ID, S_PAY and S_DISCARD; 0 in S_HOLD.
//  - Good frame: in_last=1 exactly on byte FRAME_LEN-1 -> S_HOLD.
//    out_valid rises the cycle after that byte is accepted (latency 1).
//    out_drop_id/out_payload are stable while out_valid=1.
//  - Short frame: in_last=1 on byte index < FRAME_LEN-1 (including inside the header).
//    Next cycle: err_pulse=1, err_code=01, err_cnt++. Partial frame dropped; go to S_ID, count=0.
//  - Long frame: byte FRAME_LEN-1 accepted with in_last=0.
//    Next cycle: err_pulse=1, err_code=10, err_cnt++. Go to S_DISCARD; the frame never reaches mfe.
//  - Single-byte message (in_last on byte 0) is short.
//  - Counters saturate at all-ones; no wrap.
//  - Throughput: at most one frame per FRAME_LEN+1 cycles. The handshake cycle in S_HOLD
//    takes no input byte.
//  - Input bytes are never lost while in_ready=1. in_valid may toggle arbitrarily between
//    bytes; gaps do not affect counting.
//  - out_ready asserted while out_valid=0 has no effect. If out_valid=1 and out_ready=0,
//    the frame is held indefinitely.
// STRUCTURE
//  - mfe_pkg holds:
//    typedef enum logic [1:0] {S_ID,S_PAY,S_HOLD,S_DISCARD} ingress_state_e;
//    localparam ERR_NONE=2'b00, ERR_SHORT=2'b01, ERR_LONG=2'b10.
//  - Sub-module mfe_sat_cnt #(W): clk, rst, inc -> q. Saturating up-counter, instantiated twice.
//  - Everything else (FSM, byte counter, shift registers) stays in this file.
// TESTING
//  1 Reset, then send 20 bytes 0x00..0x13 with in_last on the last byte, out_ready=1.
//    -> out_valid 1 cycle after the last byte; out_drop_id=0x00010203;
//       out_payload=0x0405..13; frame_cnt=1.
//  2 Same frame with out_ready=0 for 10 cycles.
//    -> out_valid held, data stable, in_ready=0; accepted on the out_ready cycle; in_ready=1 next.
//  3 Send 7 bytes with in_last on byte 6.
//    -> err_pulse=1/err_code=01 for 1 cycle; err_cnt=1; out_valid stays 0.
//    A following good frame is delivered intact.
//  4 Send 25 bytes with in_last only on byte 24.
//    -> err_code=10 after byte 19; bytes 20..24 swallowed; err_cnt=1; no frame delivered.
//  5 Assert rst after 10 bytes of a frame, then send a clean 20-byte frame.
//    -> no error pulse; only the clean frame delivered; counters reflect post-reset only.
//  6 Drive 70000 good frames (force the counter near max).
//    -> frame_cnt saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/mfe_pkg.sv
// ----------------------------------------------------------------------------
// mfe_pkg
// Shared types and constants for the mfe ingress path.
//   ingress_state_e : framing FSM states of mfe_ingress
//   ERR_*           : err_code encodings reported alongside err_pulse
// ----------------------------------------------------------------------------
package mfe_pkg;

    typedef enum logic [1:0] {
        S_ID,
        S_PAY,
        S_HOLD,
        S_DISCARD
    } ingress_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;

endpackage

// File: rtl/mfe_sat_cnt.sv
// ----------------------------------------------------------------------------
// mfe_sat_cnt
// Saturating up-counter used for ingress statistics. Sticks at all-ones.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears the count
//   inc  in   increment request for this cycle
//   q    out  current count (W bits)
// ----------------------------------------------------------------------------
module mfe_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mfe_ingress.sv
// ----------------------------------------------------------------------------
// mfe_ingress
// Packs an incoming byte stream into fixed-size dead-drop request frames
// (big-endian drop-ID header followed by a fixed payload), drops frames whose
// length is wrong, and hands each good frame to mfe over valid/ready.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   in_valid     byte on in_data is valid
//   in_data      stream byte
//   in_last      final byte of a message (qualified by in_valid)
//   in_ready     byte accepted when in_valid && in_ready
//   out_valid    frame held for mfe
//   out_ready    mfe takes the frame when out_valid && out_ready
//   out_drop_id  drop ID of the held frame (first header byte is MSB)
//   out_payload  payload of the held frame (first payload byte is MSB)
//   err_pulse    one-cycle pulse for a malformed frame
//   err_code     ERR_SHORT / ERR_LONG with err_pulse, ERR_NONE otherwise
//   frame_cnt    good frames delivered, saturating
//   err_cnt      malformed frames, saturating
// ----------------------------------------------------------------------------
module mfe_ingress #(
    parameter int unsigned ID_BYTES  = 4,
    parameter int unsigned MSG_BYTES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*ID_BYTES-1:0]  out_drop_id,
    output logic [8*MSG_BYTES-1:0] out_payload,
    output logic                   err_pulse,
    output logic [1:0]             err_code,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    import mfe_pkg::*;

    localparam int unsigned FRAME_LEN = ID_BYTES + MSG_BYTES;
    localparam int unsigned BC_W      = $clog2(FRAME_LEN);
    localparam int unsigned ID_W      = 8 * ID_BYTES;
    localparam int unsigned PAY_W     = 8 * MSG_BYTES;

    localparam logic [BC_W-1:0] LAST_ID_IDX  = BC_W'(ID_BYTES - 1);
    localparam logic [BC_W-1:0] LAST_BYTE_IDX = BC_W'(FRAME_LEN - 1);

    ingress_state_e   r_state;
    ingress_state_e   w_state_next;
    logic [BC_W-1:0]  r_cnt;
    logic [BC_W-1:0]  w_cnt_next;
    logic [ID_W-1:0]  r_id;
    logic [PAY_W-1:0] r_pay;
    logic             r_err_pulse;
    logic [1:0]       r_err_code;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_frame_done;
    logic             w_shift_id;
    logic             w_shift_pay;
    logic [1:0]       w_err;

    // Held low during the reset cycle so no byte is taken while state is being cleared.
    assign w_in_ready   = ~rst & (r_state != S_HOLD);
    assign w_accept     = in_valid & w_in_ready;
    assign w_frame_done = (r_state == S_HOLD) & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err        = ERR_NONE;
        w_shift_id   = 1'b0;
        w_shift_pay  = 1'b0;

        unique case (r_state)
            S_ID: begin
                if (w_accept) begin
                    w_shift_id = 1'b1;
                    if (in_last) begin
                        // Any last inside the header is short: payload is never empty.
                        w_err        = ERR_SHORT;
                        w_cnt_next   = '0;
                        w_state_next = S_ID;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                        if (r_cnt == LAST_ID_IDX) begin
                            w_state_next = S_PAY;
                        end
                    end
                end
            end

            S_PAY: begin
                if (w_accept) begin
                    w_shift_pay = 1'b1;
                    if (r_cnt == LAST_BYTE_IDX) begin
                        w_cnt_next = '0;
                        if (in_last) begin
                            w_state_next = S_HOLD;
                        end else begin
                            w_err        = ERR_LONG;
                            w_state_next = S_DISCARD;
                        end
                    end else if (in_last) begin
                        w_err        = ERR_SHORT;
                        w_cnt_next   = '0;
                        w_state_next = S_ID;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (out_ready) begin
                    w_cnt_next   = '0;
                    w_state_next = S_ID;
                end
            end

            S_DISCARD: begin
                // Swallow the tail of an over-long message up to its last byte.
                if (w_accept && in_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_ID;
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_state_next = S_ID;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ID;
            r_cnt       <= '0;
            r_id        <= '0;
            r_pay       <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_err_pulse <= (w_err != ERR_NONE);
            r_err_code  <= w_err;
            // Every good frame shifts in all header/payload bytes, so the
            // registers need no clearing between frames.
            if (w_shift_id) begin
                r_id <= (r_id << 8) | ID_W'(in_data);
            end
            if (w_shift_pay) begin
                r_pay <= (r_pay << 8) | PAY_W'(in_data);
            end
        end
    end

    mfe_sat_cnt #(
        .W (CNT_W)
    ) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_frame_done),
        .q   (frame_cnt)
    );

    mfe_sat_cnt #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err != ERR_NONE),
        .q   (err_cnt)
    );

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == S_HOLD);
    assign out_drop_id = r_id;
    assign out_payload = r_pay;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_mfe_ingress.sv
// ----------------------------------------------------------------------------
// tb_mfe_ingress
// Self-checking bench for mfe_ingress: a vector table for the basic frame and
// short-frame cases, hand-written sequences for hold/long/reset/saturation,
// and a randomized stream compared cycle by cycle against a queue-based model.
// ----------------------------------------------------------------------------
module tb_mfe_ingress;

    localparam int unsigned ID_BYTES  = 4;
    localparam int unsigned MSG_BYTES = 16;
    localparam int unsigned FRAME_LEN = ID_BYTES + MSG_BYTES;
    // Narrow statistics counters so saturation is reached within a short run.
    localparam int unsigned TB_CNT_W  = 6;
    localparam int          CMAX      = (1 << TB_CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*ID_BYTES-1:0]  out_drop_id;
    logic [8*MSG_BYTES-1:0] out_payload;
    logic                   err_pulse;
    logic [1:0]             err_code;
    logic [TB_CNT_W-1:0]    frame_cnt;
    logic [TB_CNT_W-1:0]    err_cnt;

    mfe_ingress #(
        .ID_BYTES  (ID_BYTES),
        .MSG_BYTES (MSG_BYTES),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_drop_id (out_drop_id),
        .out_payload (out_payload),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string cur_test = "init";

    // Reference model: bytes of the message being collected, plus flags.
    logic [7:0]   m_q[$];
    bit           m_hold;
    bit           m_disc;
    int           m_fcnt;
    int           m_ecnt;
    logic [1:0]   m_err;
    logic [31:0]  m_id;
    logic [127:0] m_pay;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       ordy;
        logic       e_valid;
        logic       e_pulse;
        logic [1:0] e_code;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic last,
                              input logic ordy, input logic r);
        m_err = 2'b00;
        if (r) begin
            m_q.delete();
            m_hold = 0;
            m_disc = 0;
            m_fcnt = 0;
            m_ecnt = 0;
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 0;
                if (m_fcnt < CMAX) m_fcnt++;
            end
        end else if (v) begin
            if (m_disc) begin
                if (last) m_disc = 0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == FRAME_LEN) begin
                    if (last) begin
                        m_hold = 1;
                        m_id   = '0;
                        m_pay  = '0;
                        for (int i = 0; i < int'(ID_BYTES); i++) m_id = {m_id[23:0], m_q[i]};
                        for (int i = ID_BYTES; i < int'(FRAME_LEN); i++)
                            m_pay = {m_pay[119:0], m_q[i]};
                    end else begin
                        m_err  = 2'b10;
                        m_disc = 1;
                    end
                    m_q.delete();
                end else if (last) begin
                    m_err = 2'b01;
                    m_q.delete();
                end
            end
        end
        if (m_err != 2'b00 && m_ecnt < CMAX) m_ecnt++;
    endtask

    // One clock: drive, check in_ready, clock edge, update model, check outputs.
    task automatic cycle(input logic v, input logic [7:0] d, input logic last,
                         input logic ordy, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        rst       = r;
        #1;
        chk("in_ready", 128'(in_ready), 128'(!r && !m_hold));
        @(posedge clk);
        model_step(v, d, last, ordy, r);
        #1;
        chk("out_valid", 128'(out_valid), 128'(m_hold));
        chk("err_pulse", 128'(err_pulse), 128'(m_err != 2'b00));
        chk("err_code", 128'(err_code), 128'(m_err));
        chk("frame_cnt", 128'(frame_cnt), 128'(m_fcnt));
        chk("err_cnt", 128'(err_cnt), 128'(m_ecnt));
        if (m_hold) begin
            chk("out_drop_id", 128'(out_drop_id), 128'(m_id));
            chk("out_payload", out_payload, m_pay);
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < int'(FRAME_LEN); i++)
            cycle(1'b1, base + 8'(i), (i == int'(FRAME_LEN) - 1), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    localparam logic [31:0]  EXP_ID  = 32'h00010203;
    localparam logic [127:0] EXP_PAY = 128'h0405060708090a0b0c0d0e0f10111213;

    initial begin
        int len;
        int idx;
        logic v;
        logic last;
        logic r;
        logic acc;

        // Vector table: clean 20-byte frame, handshake, then a 7-byte short message.
        for (int i = 0; i < 20; i++)
            tbl[i] = '{1'b1, 8'(i), (i == 19), 1'b1, (i == 19), 1'b0, 2'b00};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        for (int i = 0; i < 7; i++)
            tbl[21 + i] = '{1'b1, 8'(8'hA0 + i), (i == 6), 1'b1, 1'b0, (i == 6),
                            (i == 6) ? 2'b01 : 2'b00};
        tbl[28] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};

        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0; rst = 1;
        m_hold = 0; m_disc = 0; m_fcnt = 0; m_ecnt = 0; m_err = 0; m_id = 0; m_pay = 0;

        // Reset state
        cur_test = "reset";
        do_reset();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_drop_id", 128'(out_drop_id), 128'(0));
        chk("rst_payload", out_payload, 128'(0));
        chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        chk("rst_err_cnt", 128'(err_cnt), 128'(0));
        #1;
        in_valid = 0; rst = 0;
        #1;
        chk("rst_in_ready_after", 128'(in_ready), 128'(1));

        // Table-driven: good frame then short frame
        cur_test = "table";
        for (int k = 0; k < 29; k++) begin
            cycle(tbl[k].v, tbl[k].d, tbl[k].last, tbl[k].ordy, 1'b0);
            chk("tbl_valid", 128'(out_valid), 128'(tbl[k].e_valid));
            chk("tbl_pulse", 128'(err_pulse), 128'(tbl[k].e_pulse));
            chk("tbl_code", 128'(err_code), 128'(tbl[k].e_code));
            if (k == 19) begin
                chk("tbl_drop_id", 128'(out_drop_id), 128'(EXP_ID));
                chk("tbl_payload", out_payload, EXP_PAY);
            end
            if (k == 20) chk("tbl_frame_cnt", 128'(frame_cnt), 128'(1));
            if (k == 27) chk("tbl_err_cnt", 128'(err_cnt), 128'(1));
        end
        cur_test = "after_short";
        send_frame(8'h30);
        chk("after_short_frames", 128'(frame_cnt), 128'(2));

        // Backpressure: frame held for 10 cycles while bytes are offered
        cur_test = "hold";
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), (i == 19), 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_drop_id", 128'(out_drop_id), 128'(EXP_ID));
            chk("hold_payload", out_payload, EXP_PAY);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("hold_released", 128'(out_valid), 128'(0));
        chk("hold_frame_cnt", 128'(frame_cnt), 128'(1));
        chk("hold_in_ready_next", 128'(in_ready), 128'(1));
        // out_ready while nothing is held has no effect
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("idle_ready_frame_cnt", 128'(frame_cnt), 128'(1));

        // Long message: 25 bytes, last only on byte 24
        cur_test = "long";
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, 8'(8'h50 + i), (i == 24), 1'b1, 1'b0);
            if (i == 19) chk("long_code", 128'(err_code), 128'(2'b10));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("long_err_cnt", 128'(err_cnt), 128'(1));
        chk("long_frame_cnt", 128'(frame_cnt), 128'(0));
        send_frame(8'h00);
        chk("long_recover", 128'(frame_cnt), 128'(1));

        // Single-byte message is short
        cur_test = "single";
        do_reset();
        cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        chk("single_code", 128'(err_code), 128'(2'b01));

        // Reset in the middle of a frame
        cur_test = "mid_reset";
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
        do_reset();
        chk("mid_reset_pulse", 128'(err_pulse), 128'(0));
        send_frame(8'h00);
        chk("mid_reset_frames", 128'(frame_cnt), 128'(1));
        chk("mid_reset_errs", 128'(err_cnt), 128'(0));

        // Randomized stream with gaps, backpressure, bad lengths and rare resets
        cur_test = "random";
        do_reset();
        len = 20;
        idx = 0;
        for (int c = 0; c < 4000; c++) begin
            v    = ($urandom % 4) != 0;
            last = v ? (idx == len - 1) : 1'($urandom % 2);
            r    = ($urandom % 400) == 0;
            acc  = v && !r && !m_hold;
            cycle(v, 8'($urandom), last, 1'(($urandom % 3) != 0), r);
            if (r || acc) begin
                idx = r ? 0 : idx + 1;
                if (r || idx == len) begin
                    idx = 0;
                    case ($urandom % 4)
                        0, 1:    len = 20;
                        2:       len = $urandom_range(1, 19);
                        default: len = $urandom_range(21, 26);
                    endcase
                end
            end
        end

        // Counter saturation
        cur_test = "saturate";
        do_reset();
        for (int f = 0; f < CMAX + 7; f++) send_frame(8'(f));
        chk("sat_frame_cnt", 128'(frame_cnt), 128'(CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
